// File: rtl/issue_scoreboard.sv
// Dual-issue RAW/WAW hazard scoreboard: per-register saturating pending-write
// counters gate same-cycle issue of slot 0 and the younger slot 1.
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            s0_valid,
    input  logic [4:0]      s0_rd,
    input  logic [4:0]      s0_rj,
    input  logic [4:0]      s0_rk,
    input  logic            s0_use_rj,
    input  logic            s0_use_rk,
    input  logic            s0_wr,
    input  logic            s1_valid,
    input  logic [4:0]      s1_rd,
    input  logic [4:0]      s1_rj,
    input  logic [4:0]      s1_rk,
    input  logic            s1_use_rj,
    input  logic            s1_use_rk,
    input  logic            s1_wr,
    input  logic            wb0_en,
    input  logic [4:0]      wb0_addr,
    input  logic            wb1_en,
    input  logic [4:0]      wb1_addr,
    output logic            issue0,
    output logic            issue1,
    output logic [NREG-1:0] busy_vec,
    output logic [31:0]     hazard_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_p1 [NREG];
    logic [CNT_W-1:0] eff_p0 [NREG];
    logic [CNT_W-1:0] nxt_p0 [NREG];
    logic [NREG-1:0]  busy_nxt_p0;

    logic s0_rj_rdy, s0_rk_rdy, s0_dst_ok;
    logic s1_rj_rdy, s1_rk_rdy, s1_dst_ok;
    logic pair_conf, blk;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] h);
        logic [CNT_W+1:0] cw, hw;
        cw = (CNT_W+2)'(c);
        hw = (CNT_W+2)'(h);
        return (cw > hw) ? CNT_W'(cw - hw) : '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] n);
        logic [CNT_W+1:0] sw;
        sw = (CNT_W+2)'(c) + (CNT_W+2)'(n);
        return (sw > (CNT_W+2)'(CNT_MAX)) ? CNT_MAX : CNT_W'(sw);
    endfunction

    // Stage p0: writeback bypass folded into an effective pending count
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0)
                eff_p0[r] = '0;
            else
                eff_p0[r] = sat_dec(cnt_p1[r],
                                    {1'b0, wb0_en && (wb0_addr == 5'(r))} +
                                    {1'b0, wb1_en && (wb1_addr == 5'(r))});
        end
    end

    assign s0_rj_rdy = (s0_rj == '0) || (eff_p0[s0_rj] == '0);
    assign s0_rk_rdy = (s0_rk == '0) || (eff_p0[s0_rk] == '0);
    assign s1_rj_rdy = (s1_rj == '0) || (eff_p0[s1_rj] == '0);
    assign s1_rk_rdy = (s1_rk == '0) || (eff_p0[s1_rk] == '0);
    assign s0_dst_ok = (s0_rd == '0) || (cnt_p1[s0_rd] != CNT_MAX);
    assign s1_dst_ok = (s1_rd == '0) || (cnt_p1[s1_rd] != CNT_MAX);

    // Slot 1 may not consume or overwrite what slot 0 writes this same cycle
    assign pair_conf = s0_wr && (s0_rd != '0) &&
                       ((s1_use_rj && (s0_rd == s1_rj)) ||
                        (s1_use_rk && (s0_rd == s1_rk)) ||
                        (s1_wr && (s0_rd == s1_rd)));

    assign blk = rst || flush;

    assign issue0 = !blk && s0_valid && !stall &&
                    (!s0_use_rj || s0_rj_rdy) && (!s0_use_rk || s0_rk_rdy) &&
                    (!s0_wr || s0_dst_ok);

    assign issue1 = issue0 && s1_valid &&
                    (!s1_use_rj || s1_rj_rdy) && (!s1_use_rk || s1_rk_rdy) &&
                    (!s1_wr || s1_dst_ok) && !pair_conf;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0)
                nxt_p0[r] = '0;
            else
                nxt_p0[r] = sat_inc(eff_p0[r],
                                    {1'b0, issue0 && s0_wr && (s0_rd == 5'(r))} +
                                    {1'b0, issue1 && s1_wr && (s1_rd == 5'(r))});
            busy_nxt_p0[r] = (nxt_p0[r] != '0);
        end
    end

    // Stage p1: registered counters, busy vector and hazard statistics
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < NREG; r++) cnt_p1[r] <= '0;
            busy_vec <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_p1[r] <= nxt_p0[r];
            busy_vec <= busy_nxt_p0;
        end

        if (rst)
            hazard_cycles <= '0;
        else if (s0_valid && !issue0 && !stall)
            hazard_cycles <= hazard_cycles + 32'd1;
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vector table, hand-built
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_issue_scoreboard;

    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, flush = 1'b0, stall = 1'b0;
    logic s0_valid = 1'b0, s0_use_rj = 1'b0, s0_use_rk = 1'b0, s0_wr = 1'b0;
    logic s1_valid = 1'b0, s1_use_rj = 1'b0, s1_use_rk = 1'b0, s1_wr = 1'b0;
    logic [4:0] s0_rd = '0, s0_rj = '0, s0_rk = '0;
    logic [4:0] s1_rd = '0, s1_rj = '0, s1_rk = '0;
    logic wb0_en = 1'b0, wb1_en = 1'b0;
    logic [4:0] wb0_addr = '0, wb1_addr = '0;
    logic issue0, issue1;
    logic [NREG-1:0] busy_vec;
    logic [31:0] hazard_cycles;

    issue_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_rj(s0_rj), .s0_rk(s0_rk),
        .s0_use_rj(s0_use_rj), .s0_use_rk(s0_use_rk), .s0_wr(s0_wr),
        .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_rj(s1_rj), .s1_rk(s1_rk),
        .s1_use_rj(s1_use_rj), .s1_use_rk(s1_use_rk), .s1_wr(s1_wr),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb1_en(wb1_en), .wb1_addr(wb1_addr),
        .issue0(issue0), .issue1(issue1),
        .busy_vec(busy_vec), .hazard_cycles(hazard_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: pending writes per register and hazard counter
    int cnt_m [NREG];
    int unsigned hz_m = 0;
    bit e0, e1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int hits(input int r);
        return ((wb0_en && wb0_addr == 5'(r)) ? 1 : 0) + ((wb1_en && wb1_addr == 5'(r)) ? 1 : 0);
    endfunction

    function automatic int effm(input int r);
        int v;
        v = cnt_m[r] - hits(r);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit rdy(input int r);
        return (r == 0) || (effm(r) == 0);
    endfunction

    function automatic bit dok(input int r);
        return (r == 0) || (cnt_m[r] < MAXC);
    endfunction

    function automatic logic [31:0] busy_m();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < NREG; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    task automatic predict();
        bit conf;
        e0 = !rst && !flush && s0_valid && !stall &&
             (!s0_use_rj || rdy(int'(s0_rj))) && (!s0_use_rk || rdy(int'(s0_rk))) &&
             (!s0_wr || dok(int'(s0_rd)));
        conf = s0_wr && s0_rd != 0 &&
               ((s1_use_rj && s0_rd == s1_rj) || (s1_use_rk && s0_rd == s1_rk) ||
                (s1_wr && s0_rd == s1_rd));
        e1 = e0 && s1_valid &&
             (!s1_use_rj || rdy(int'(s1_rj))) && (!s1_use_rk || rdy(int'(s1_rk))) &&
             (!s1_wr || dok(int'(s1_rd))) && !conf;
    endtask

    task automatic model_update();
        int nc [NREG];
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
            hz_m = 0;
        end else begin
            if (s0_valid && !e0 && !stall) hz_m = hz_m + 1;
            for (int r = 0; r < NREG; r++) begin
                nc[r] = 0;
                if (!flush && r != 0) begin
                    nc[r] = effm(r);
                    if (e0 && s0_wr && int'(s0_rd) == r) nc[r]++;
                    if (e1 && s1_wr && int'(s1_rd) == r) nc[r]++;
                end
            end
            for (int r = 0; r < NREG; r++) cnt_m[r] = nc[r];
        end
    endtask

    // Inputs are set just after a rising edge; one call covers one clock cycle.
    task automatic step(input int x0 = -1, input int x1 = -1);
        #2;
        predict();
        chk("issue0", {31'd0, issue0}, {31'd0, e0});
        chk("issue1", {31'd0, issue1}, {31'd0, e1});
        chk("busy_vec", busy_vec, busy_m());
        chk("hazard_cycles", hazard_cycles, hz_m);
        if (x0 >= 0) chk("issue0_const", {31'd0, issue0}, 32'(x0));
        if (x1 >= 0) chk("issue1_const", {31'd0, issue1}, 32'(x1));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; stall = 0;
        s0_valid = 0; s0_rd = 0; s0_rj = 0; s0_rk = 0; s0_use_rj = 0; s0_use_rk = 0; s0_wr = 0;
        s1_valid = 0; s1_rd = 0; s1_rj = 0; s1_rk = 0; s1_use_rj = 0; s1_use_rk = 0; s1_wr = 0;
        wb0_en = 0; wb0_addr = 0; wb1_en = 0; wb1_addr = 0;
    endtask

    task automatic set_s0(input logic v, input logic [4:0] rd, input logic [4:0] rj,
                          input logic uj, input logic w);
        s0_valid = v; s0_rd = rd; s0_rj = rj; s0_use_rj = uj; s0_wr = w;
        s0_rk = 0; s0_use_rk = 0;
    endtask

    task automatic set_s1(input logic v, input logic [4:0] rd, input logic [4:0] rj,
                          input logic uj, input logic w);
        s1_valid = v; s1_rd = rd; s1_rj = rj; s1_use_rj = uj; s1_wr = w;
        s1_rk = 0; s1_use_rk = 0;
    endtask

    typedef struct {
        logic       s0v; logic [4:0] s0rd; logic [4:0] s0rj; logic s0uj; logic s0w;
        logic       s1v; logic [4:0] s1rd; logic [4:0] s1rj; logic s1uj; logic s1w;
        logic       wbe; logic [4:0] wba;
        int         x0;  int x1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        for (int r = 0; r < NREG; r++) cnt_m[r] = 0;

        tbl[0] = '{1, 5, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0,  1, 0}; // allocate r5
        tbl[1] = '{1, 0, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0}; // RAW on r5 stalls
        tbl[2] = '{1, 0, 5, 1, 0,  0, 0, 0, 0, 0,  1, 5,  1, 0}; // bypass from wb0
        tbl[3] = '{1, 3, 0, 0, 1,  1, 0, 3, 1, 0,  0, 0,  1, 0}; // intra-pair RAW
        tbl[4] = '{1, 3, 0, 0, 1,  1, 3, 0, 0, 1,  0, 0,  1, 0}; // intra-pair WAW
        tbl[5] = '{1, 0, 0, 0, 1,  1, 0, 0, 0, 1,  0, 0,  1, 1}; // r0 never conflicts
        tbl[6] = '{1, 6, 0, 0, 1,  1, 8, 2, 1, 1,  0, 0,  1, 1}; // dual allocate
        tbl[7] = '{1, 0, 8, 1, 0,  1, 0, 6, 1, 0,  1, 8,  1, 0}; // s0 bypassed, s1 waits

        // Reset for two cycles with a candidate present
        idle();
        rst = 1; set_s0(1, 5, 0, 0, 1);
        @(posedge clk); #1;
        step(0, 0);
        step(0, 0);
        idle();
        #1;
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_hazard", hazard_cycles, 32'd0);

        for (int i = 0; i < 8; i++) begin
            idle();
            set_s0(tbl[i].s0v, tbl[i].s0rd, tbl[i].s0rj, tbl[i].s0uj, tbl[i].s0w);
            set_s1(tbl[i].s1v, tbl[i].s1rd, tbl[i].s1rj, tbl[i].s1uj, tbl[i].s1w);
            wb0_en = tbl[i].wbe; wb0_addr = tbl[i].wba;
            step(tbl[i].x0, tbl[i].x1);
        end
        idle();
        #1;
        chk("tbl_busy5_clear", {31'd0, busy_vec[5]}, 32'd0);
        chk("tbl_busy3_set", {31'd0, busy_vec[3]}, 32'd1);
        chk("tbl_hazard", hazard_cycles, 32'd1);

        // Saturation on r7, then a double writeback nets two off
        idle(); set_s0(1, 7, 0, 0, 1);
        step(1, 0); step(1, 0); step(1, 0);
        step(0, 0);
        idle(); wb0_en = 1; wb0_addr = 7; wb1_en = 1; wb1_addr = 7;
        step(0, 0);
        idle(); set_s0(1, 0, 7, 1, 0);
        step(0, 0);
        wb0_en = 1; wb0_addr = 7;
        step(1, 0);
        idle();
        #1;
        chk("sat_busy7_clear", {31'd0, busy_vec[7]}, 32'd0);

        // Flush with work in flight and valid candidates
        idle(); set_s0(1, 4, 0, 0, 1);
        step(1, 0); step(1, 0);
        set_s0(1, 9, 0, 0, 1);
        step(1, 0);
        flush = 1; set_s0(1, 10, 0, 0, 1); set_s1(1, 11, 0, 0, 1);
        step(0, 0);
        idle();
        #1;
        chk("flush_busy", busy_vec, 32'd0);
        step();

        // Stall blocks ready candidates while writeback still retires
        idle(); set_s0(1, 12, 0, 0, 1);
        step(1, 0);
        stall = 1; set_s0(1, 13, 0, 0, 1); set_s1(1, 14, 0, 0, 1);
        wb0_en = 1; wb0_addr = 12;
        step(0, 0);
        idle();
        #1;
        chk("stall_busy12_clear", {31'd0, busy_vec[12]}, 32'd0);
        step();

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 31) == 0);
            stall = ($urandom_range(0, 7) == 0);
            s0_valid = ($urandom_range(0, 7) != 0);
            s0_rd = 5'($urandom_range(0, 7)); s0_rj = 5'($urandom_range(0, 7));
            s0_rk = 5'($urandom_range(0, 7));
            s0_use_rj = 1'($urandom); s0_use_rk = 1'($urandom); s0_wr = 1'($urandom);
            s1_valid = 1'($urandom);
            s1_rd = 5'($urandom_range(0, 7)); s1_rj = 5'($urandom_range(0, 7));
            s1_rk = 5'($urandom_range(0, 7));
            s1_use_rj = 1'($urandom); s1_use_rk = 1'($urandom); s1_wr = 1'($urandom);
            wb0_en = 1'($urandom); wb0_addr = 5'($urandom_range(0, 7));
            wb1_en = 1'($urandom); wb1_addr = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Dual-issue RAW/WAW hazard scheduler that sits between the decode/issue queue head and the register-file read stage.
- Keeps a saturating pending-write counter per architectural register and decides each cycle whether slot 0, slots 0+1, or neither may advance into register read.
- Treats the register file's same-cycle writeback bypass as a valid operand source, so a register whose last pending write retires this cycle counts as ready.

Parameters:
- NREG, 32, number of architectural registers; r0 is never tracked.
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; clears all pending state.
- stall  in  1  downstream stall; when high, nothing issues.
- s0_valid  in  1  slot-0 candidate present.
- s0_rd  in  5  slot-0 destination register.
- s0_rj  in  5  slot-0 source register 1.
- s0_rk  in  5  slot-0 source register 2.
- s0_use_rj  in  1  slot 0 reads rj.
- s0_use_rk  in  1  slot 0 reads rk.
- s0_wr  in  1  slot 0 writes rd.
- s1_valid, s1_rd, s1_rj, s1_rk, s1_use_rj, s1_use_rk, s1_wr  in  1/5/5/5/1/1/1  same fields for slot 1, younger in program order.
- wb0_en  in  1  writeback port 0 valid.
- wb0_addr  in  5  writeback port 0 register.
- wb1_en  in  1  writeback port 1 valid.
- wb1_addr  in  5  writeback port 1 register.
- issue0  out  1  slot 0 accepted this cycle (combinational).
- issue1  out  1  slot 1 accepted this cycle (combinational).
- busy_vec  out  NREG  registered; bit i=1 when cnt[i]!=0.
- hazard_cycles  out  32  registered count of cycles with s0_valid&&!issue0&&!stall.

Behaviour:
- Reset/flush: on rst or flush (rst has priority; both synchronous), all cnt clear to 0 and busy_vec clears to 0.
  - rst also clears hazard_cycles to 0; flush does not.
  - issue0 and issue1 are forced to 0 in any cycle where rst or flush is high.
- Writeback hits: hit(r) = (wb0_en&&wb0_addr==r) + (wb1_en&&wb1_addr==r), range 0..2.
  - Effective count eff(r) = cnt[r] - hit(r), saturating at 0.
  - A writeback to a register whose cnt is 0 is ignored; no underflow.
- Source ready: ready(r) = (r==0) || eff(r)==0.
- Destination ok: dst_ok(r) = (r==0) || cnt[r] < 2^CNT_W-1. Counter saturation blocks issue; it is structural back-pressure.
- issue0 = s0_valid && !stall && (!s0_use_rj||ready(s0_rj)) && (!s0_use_rk||ready(s0_rk)) && (!s0_wr||dst_ok(s0_rd)).
- issue1 = issue0 && s1_valid && slot-1 source checks (same form as slot 0) && slot-1 dst_ok && no intra-pair conflict.
  - Intra-pair conflict: s0_wr && s0_rd!=0 && (s0_rd==s1_rj&&s1_use_rj || s0_rd==s1_rk&&s1_use_rk || s1_wr&&s0_rd==s1_rd).
  - Slot 1 never issues without slot 0; issue is strictly in order.
- Counter update each cycle, for every r!=0:
  - cnt[r] <= eff(r) + (issue0&&s0_wr&&s0_rd==r) + (issue1&&s1_wr&&s1_rd==r).
  - At most one increment per register, guaranteed by the WAW check.
  - Simultaneous increment and decrement on the same register nets out in the same cycle.
- Latency: issue decisions are same-cycle combinational. Counter and busy_vec effects are visible from the next cycle.
- cnt[0] stays 0 permanently; writes to r0 never allocate.
- hazard_cycles wraps at 2^32.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> busy_vec=0, hazard_cycles=0, issue0=issue1=0. Then s0 rd=5 wr=1, valid -> issue0=1, next cycle busy_vec[5]=1.
- RAW stall/bypass: cnt[5]=1. s0 uses rj=5 -> issue0=0 and hazard_cycles increments. Same cycle with wb0_en=1, wb0_addr=5 -> issue0=1 and cnt[5] ends at 0.
- Intra-pair: s0 rd=3 wr; s1 rj=3 -> issue0=1, issue1=0. s1 rd=3 wr, no rj/rk use -> issue1=0. Destination r0 in both -> issue1=1.
- Saturation: issue 3 writes to r7 with no writeback -> cnt[7]=3; a 4th writer to r7 -> issue0=0. wb0 and wb1 both to r7 -> cnt[7]=1 next cycle.
- Flush mid-flight: cnt[4]=2, cnt[9]=1, flush=1 with valid candidates -> issue0=0; next cycle busy_vec=0 and hazard_cycles retained.
- Stall: stall=1 with ready candidates -> issue0=issue1=0 and hazard_cycles unchanged; a concurrent writeback still decrements its counter.
